instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the single-issue RISC pipeline: owns the program counter, requests instruction words from instruction memory over a req/ready handshake, and presents the current 32-bit instruction word to the instruction decoder's `IR` input. A one-entry skid buffer absorbs memory responses while decode is stalled. A branch/jump redirect from the execute stage flushes fetched words and restarts fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.
- `clk`  in  1: clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: instruction memory request.
- `imem_addr`  out  32: word address of request; held stable while `imem_req`=1 until `imem_ready`.
- `imem_ready`  in  1: response valid; meaningful only while `imem_req`=1.
- `imem_rdata`  in  32: instruction word, valid with `imem_ready`.
- `ir`  out  32: instruction word to decoder; forced to 32'h0 (NOP) whenever `ir_valid`=0.
- `ir_valid`  out  1: `ir` holds a live instruction.
- `ir_pc`  out  32: word address of the instruction in `ir`; used for PC-relative targets.
- `ir_stall`  in  1: downstream not accepting `ir` this cycle.
- `br_take`  in  1: redirect pulse from branch unit (BZ/BNZ/JMP/JMR/JML resolution).
- `br_target`  in  32: redirect word address, valid with `br_take`.
- `fetch_count`  out  16: instructions loaded into `ir` (see Configuration).
- `flush_count`  out  16: redirects taken (see Configuration).

## Operation
- Internal: `pc` (next fetch address), `hold` register + `hold_pc`, state ∈ {FETCH, HOLD, KILL}.
- `accept` = `ir_valid` & ~`ir_stall`; `slot_free` = ~`ir_valid` | `accept`.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ready`: `pc` ← `pc`+1 (wraps 32'hFFFF_FFFF → 0). If `slot_free`: `ir` ← rdata, `ir_pc` ← old `pc`, `ir_valid` ← 1, stay FETCH. Else: `hold` ← rdata, `hold_pc` ← old `pc`, → HOLD. No `imem_ready` and `accept`: `ir_valid` ← 0.
- HOLD: `imem_req`=0. On `accept`: `ir` ← `hold`, `ir_pc` ← `hold_pc`, → FETCH.
- KILL: `imem_req`=1, `imem_addr` = abandoned address (held). On `imem_ready`: data discarded, → FETCH. `ir_valid`=0 throughout.
- Redirect (`br_take`=1) has priority over everything except reset: `pc` ← `br_target`, `ir_valid` ← 0, `hold` discarded. Next state: KILL if in FETCH with `imem_req`=1 and `imem_ready`=0; else FETCH. `br_take` coincident with `imem_ready`: returned word discarded, next request at `br_target`.
- `br_take` in KILL: `pc` ← new `br_target`, remain KILL.
- `ir_stall` ignored while `ir_valid`=0.

## Timing
- Reset values: state FETCH, `pc`=`RESET_PC`, `ir_valid`=0, `ir`=0, `ir_pc`=0, `hold`=0, counters 0; `imem_req`=0 during reset cycle.
- First request: cycle after reset deasserts, `imem_addr`=`RESET_PC`.
- Latency: `imem_ready` in cycle N → `ir_valid`=1 in N+1.
- Throughput: zero-wait memory, no stall → one instruction per cycle, `imem_req` continuously high.
- Redirect penalty: `br_take` in cycle N → request at `br_target` in N+1 (N+1+k if KILL waits k cycles for ready).
- Reset mid-transaction: outstanding request abandoned; memory must tolerate `imem_req` dropping.

## Configuration
- `IFU_PERF_CNT_EN` defined: `fetch_count` increments on every load into `ir` (from memory or `hold`); `flush_count` increments on every `br_take` cycle; both 16-bit, wrap at 16'hFFFF → 0, cleared by reset.
- Not defined: counter logic absent; `fetch_count` and `flush_count` tied to 16'h0.

## Test plan
- Reset with `RESET_PC`=32'h40, zero-wait memory returning `imem_rdata`=addr, no stall → `imem_addr` 0x40,0x41,0x42 on consecutive cycles; `ir` 0x40,0x41,0x42 one cycle later; `ir_pc`=`ir`.
- Hold `ir_stall`=1 for 3 cycles while `ir`=0x41 → word 0x42 into `hold`, `imem_req`=0 for stall duration; on release `ir`=0x42 next cycle, then fetch resumes at 0x43; no word lost or duplicated.
- `br_take`=1, `br_target`=0x100 while `ir_valid`=1 and `hold` full → `ir_valid`=0 next cycle, `hold` dropped, next `imem_addr`=0x100.
- 3-wait-state memory, `br_take` (target 0x200) one cycle into request for 0x10 → `imem_addr` stays 0x10 until ready, data discarded, then request 0x200; `ir_valid` never 1 for 0x10.
- `pc`=32'hFFFF_FFFF fetched → next `imem_addr`=0x0.
- With `IFU_PERF_CNT_EN`: 5 fetched instructions and 2 redirects → `fetch_count`=5, `flush_count`=2; without macro both read 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage of the single-issue RISC pipeline.
// Owns the PC, issues instruction memory requests over a req/ready handshake,
// and presents the fetched word to decode, with a one-entry skid buffer for
// decode stalls and a KILL state that drains a request abandoned by a redirect.
// Optional feature macro: IFU_PERF_CNT_EN enables the fetch/flush counters;
// without it both counter outputs are tied to zero.

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    output logic [31:0] ir_pc,
    input  logic        ir_stall,
    input  logic        br_take,
    input  logic [31:0] br_target,
    output logic [15:0] fetch_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold;
    logic [31:0] hold_pc;
    logic [31:0] kill_addr;
    logic [31:0] ir_reg;
    logic        ir_valid_reg;
    logic [31:0] ir_pc_reg;
    logic        accept;
    logic        slot_free;

    // Handshake with decode: a live word leaves IR when decode is not stalled.
    always_comb begin
        accept    = ir_valid_reg & ~ir_stall;
        slot_free = ~ir_valid_reg | accept;
    end

    // Memory request: only HOLD stops requesting; KILL keeps the abandoned address on the bus.
    always_comb begin
        imem_req  = ~reset & (state != HOLD);
        imem_addr = (state == KILL) ? kill_addr : pc;
    end

    // IR is forced to NOP whenever it holds no live instruction.
    always_comb begin
        ir       = ir_valid_reg ? ir_reg : 32'h0;
        ir_valid = ir_valid_reg;
        ir_pc    = ir_pc_reg;
    end

    // Main fetch FSM: redirect outranks everything but reset and flushes IR and the skid buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            hold         <= 32'h0;
            hold_pc      <= 32'h0;
            kill_addr    <= 32'h0;
            ir_reg       <= 32'h0;
            ir_valid_reg <= 1'b0;
            ir_pc_reg    <= 32'h0;
        end else if (br_take) begin
            pc           <= br_target;
            ir_valid_reg <= 1'b0;
            if (state == FETCH) begin
                kill_addr <= pc;
            end
            if ((state != HOLD) && !imem_ready) begin
                state <= KILL;
            end else begin
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        pc <= pc + 32'd1;
                        if (slot_free) begin
                            ir_reg       <= imem_rdata;
                            ir_pc_reg    <= pc;
                            ir_valid_reg <= 1'b1;
                        end else begin
                            hold    <= imem_rdata;
                            hold_pc <= pc;
                            state   <= HOLD;
                        end
                    end else if (accept) begin
                        ir_valid_reg <= 1'b0;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        ir_reg    <= hold;
                        ir_pc_reg <= hold_pc;
                        state     <= FETCH;
                    end
                end
                KILL: begin
                    if (imem_ready) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic        load_ir;
    logic [15:0] fetch_cnt;
    logic [15:0] flush_cnt;

    // A load into IR comes either straight from memory or from the skid buffer.
    always_comb begin
        load_ir = ~br_take &
                  (((state == FETCH) & imem_ready & slot_free) |
                   ((state == HOLD) & accept));
    end

    // Performance counters, free-running and wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= 16'h0;
            flush_cnt <= 16'h0;
        end else begin
            if (load_ir) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (br_take) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt;
    assign flush_count = flush_cnt;
`else
    assign fetch_count = 16'h0;
    assign flush_count = 16'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit with RESET_PC = 0x40.
// The memory model returns the requested address as the instruction word.

module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] ir_pc;
    logic        ir_stall;
    logic        br_take;
    logic [31:0] br_target;
    logic [15:0] fetch_count;
    logic [15:0] flush_count;

    int passCount = 0;
    int checkCount = 0;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] eIr;
    } vec_t;

    vec_t vecs[15];

    instruction_fetch_unit #(.RESET_PC(32'h40)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .ir_pc       (ir_pc),
        .ir_stall    (ir_stall),
        .br_take     (br_take),
        .br_target   (br_target),
        .fetch_count (fetch_count),
        .flush_count (flush_count)
    );

    assign imem_rdata = imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic rdy, logic stall, logic br, logic [31:0] tgt,
                                logic eReq, logic [31:0] eAddr, logic eValid, logic [31:0] eIr);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.stall = stall; v.br = br; v.tgt = tgt;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.eIr = eIr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs just after a falling edge, then settle before sampling.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic stall,
                                 input logic br, input logic [31:0] tgt);
        reset      = rst;
        imem_ready = rdy;
        ir_stall   = stall;
        br_take    = br;
        br_target  = tgt;
        #1;
    endtask

    // Compare the visible fetch outputs; address and ir_pc only matter when meaningful.
    task automatic checkFetch(input string tag, input logic eReq, input logic [31:0] eAddr,
                              input logic eValid, input logic [31:0] eIr);
        checkOutput({tag, ".req"}, {31'b0, imem_req}, {31'b0, eReq});
        if (eReq) checkOutput({tag, ".addr"}, imem_addr, eAddr);
        checkOutput({tag, ".valid"}, {31'b0, ir_valid}, {31'b0, eValid});
        checkOutput({tag, ".ir"}, ir, eIr);
        if (eValid) checkOutput({tag, ".ir_pc"}, ir_pc, eIr);
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] expFetch;
        logic [15:0] expFlush;

        // Sequential fetch, 3-cycle stall into the skid buffer, redirect with hold full.
        vecs[0]  = mk(1, 0, 0, 0, 0,     0, 32'h40,  0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 0, 0,     1, 32'h40,  0, 32'h0);
        vecs[2]  = mk(0, 1, 0, 0, 0,     1, 32'h41,  1, 32'h40);
        vecs[3]  = mk(0, 1, 1, 0, 0,     1, 32'h42,  1, 32'h41);
        vecs[4]  = mk(0, 0, 1, 0, 0,     0, 32'h0,   1, 32'h41);
        vecs[5]  = mk(0, 0, 1, 0, 0,     0, 32'h0,   1, 32'h41);
        vecs[6]  = mk(0, 0, 0, 0, 0,     0, 32'h0,   1, 32'h41);
        vecs[7]  = mk(0, 1, 0, 0, 0,     1, 32'h43,  1, 32'h42);
        vecs[8]  = mk(0, 1, 0, 0, 0,     1, 32'h44,  1, 32'h43);
        vecs[9]  = mk(0, 1, 1, 0, 0,     1, 32'h45,  1, 32'h44);
        vecs[10] = mk(0, 0, 1, 1, 32'h100, 0, 32'h0, 1, 32'h44);
        vecs[11] = mk(0, 0, 0, 0, 0,     1, 32'h100, 0, 32'h0);
        vecs[12] = mk(0, 1, 0, 0, 0,     1, 32'h100, 0, 32'h0);
        vecs[13] = mk(0, 0, 0, 0, 0,     1, 32'h101, 1, 32'h100);
        vecs[14] = mk(0, 0, 0, 0, 0,     1, 32'h101, 0, 32'h0);

        reset = 1'b1; imem_ready = 1'b0; ir_stall = 1'b0; br_take = 1'b0; br_target = 32'h0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].stall, vecs[i].br, vecs[i].tgt);
            checkFetch($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eAddr, vecs[i].eValid, vecs[i].eIr);
            nextCycle();
        end

        // Redirect coincident with ready drops the word and restarts at 0x10.
        applyStimulus(0, 1, 0, 1, 32'h10);
        checkFetch("brRdy", 1, 32'h101, 0, 32'h0);
        nextCycle();
        // 3-wait-state request for 0x10, redirected one cycle in.
        applyStimulus(0, 0, 0, 0, 0);
        checkFetch("wait0", 1, 32'h10, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h200);
        checkFetch("wait1", 1, 32'h10, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        checkFetch("kill2", 1, 32'h10, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 1, 0, 0, 0);
        checkFetch("kill3", 1, 32'h10, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 1, 0, 0, 0);
        checkFetch("tgt200", 1, 32'h200, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        checkFetch("ir200", 1, 32'h201, 1, 32'h200);
        nextCycle();

        // PC wrap from 0xFFFF_FFFF to 0.
        applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFF);
        checkFetch("brWrap", 1, 32'h201, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 1, 0, 0, 0);
        checkFetch("fetchMax", 1, 32'hFFFF_FFFF, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        checkFetch("wrapZero", 1, 32'h0, 1, 32'hFFFF_FFFF);
        nextCycle();

        // Counters: reset, five loads, two redirects (second one while in KILL).
        applyStimulus(1, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("fetchCntRst", {16'b0, fetch_count}, 32'h0);
        checkOutput("flushCntRst", {16'b0, flush_count}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput($sformatf("cntFetch%0d", i), imem_addr, 32'h40 + i);
        end
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h300);
        checkFetch("br1", 1, 32'h45, 1, 32'h44);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h400);
        checkFetch("br2InKill", 1, 32'h45, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        checkFetch("killHold", 1, 32'h45, 0, 32'h0);
`ifdef IFU_PERF_CNT_EN
        expFetch = 16'd5;
        expFlush = 16'd2;
`else
        expFetch = 16'd0;
        expFlush = 16'd0;
`endif
        checkOutput("fetchCount", {16'b0, fetch_count}, {16'b0, expFetch});
        checkOutput("flushCount", {16'b0, flush_count}, {16'b0, expFlush});
        nextCycle();
        applyStimulus(0, 1, 0, 0, 0);
        checkFetch("killDone", 1, 32'h45, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        checkFetch("tgt400", 1, 32'h400, 0, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
